display_scan_ctrl: RTL
======================

# display_scan_ctrl

Time-multiplexing controller that shares one `SegmentDecoder`-style BCD-to-7-segment decoder among `NUM_DIGITS` common-cathode digits. It holds a double-buffered display word, drives the shared decoder's BCD inputs, and scans one-hot digit enables with an anti-ghosting blank gap between digits. It optionally suppresses leading zeros and blanks invalid (10–15) BCD codes. It sits between the host logic that produces the display value and the decoder/digit-driver pins.

## Interface
Parameters:
- `NUM_DIGITS`, 4: digits scanned per frame (2–8).
- `SHOW_CYCLES`, 50000: clocks each digit is lit per slot (≥1).
- `BLANK_CYCLES`, 500: clocks with all digits off before each slot (≥1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: 1 = scan, 0 = display dark.
- `blank_lz` in 1: 1 = suppress leading zeros.
- `load` in 1: one-cycle strobe that captures `value_in`.
- `value_in` in 4*NUM_DIGITS: BCD digits; digit i is `[4i+3:4i]`; digit 0 is rightmost.
- `b0`,`b1`,`b2`,`b3` out 1 each: BCD to the shared decoder (b0 = LSB), registered.
- `dig_en` out NUM_DIGITS: active-high one-hot digit enable, registered.
- `load_ack` out 1: one-cycle pulse when pending data becomes active.
- `frame_tick` out 1: one-cycle pulse at the end of each full scan.
- `bcd_err` out 1: sticky flag, set when an active digit is 10–15; cleared by `rst` only.

## Operation
- Storage: `pending` (4*NUM_DIGITS bits), `pend_v`, `active` (4*NUM_DIGITS bits), digit index `idx`, cycle counter `cnt`.
  - Counter width: clog2(max(SHOW_CYCLES, BLANK_CYCLES)).
- Load handshake:
  - `load`=1 captures `value_in` into `pending` and sets `pend_v`.
  - A second `load` before transfer overwrites `pending`; latest wins, and only one `load_ack` results.
- Transfer (`active` ← `pending`, `pend_v` ← 0, `load_ack`=1 for one cycle) happens:
  - at a frame boundary, or
  - on any cycle in IDLE when `pend_v`=1.
- If `load` coincides with a transfer, the old pending word transfers and the new word stays pending (`pend_v` remains 1).
- FSM states:
  - IDLE: `dig_en`=0, `idx`=0, `cnt`=0. `enable`=1 → BLANK.
  - BLANK: `dig_en`=0. On entry, `{b3..b0}` ← `active` digit `idx`. After BLANK_CYCLES clocks → SHOW.
  - SHOW: `dig_en` = (1<<`idx`) unless the digit is suppressed, in which case `dig_en`=0. After SHOW_CYCLES clocks:
    - if `idx`=NUM_DIGITS-1: `idx` ← 0, `frame_tick` pulses, frame boundary → BLANK;
    - else `idx` ← `idx`+1 → BLANK.
  - `enable`=0 in any state → IDLE next cycle; `dig_en` goes 0 on that edge.
- Suppression rules:
  - Codes 10–15: digit suppressed and `bcd_err` set when the digit enters SHOW.
  - `blank_lz`=1: digit i>0 is suppressed when all `active` digits i..NUM_DIGITS-1 are zero. Digit 0 is never suppressed for leading zeros.
- `frame_tick` does not pulse when a frame is aborted by `enable`=0.

## Timing
- Reset values: `{b3..b0}`=0, `dig_en`=0, `load_ack`=0, `frame_tick`=0, `bcd_err`=0, `active`=0, `pending`=0, `pend_v`=0, state IDLE.
- `rst` has priority over all inputs; reset mid-scan darkens the display on the next edge.
- All outputs are registered; there is no combinational path from any input to any output.
- BCD changes only on BLANK entry, so the decoder settles while all digits are off.
- Slot length: BLANK_CYCLES+SHOW_CYCLES. Frame length: NUM_DIGITS × (BLANK_CYCLES+SHOW_CYCLES).
- `enable` 0→1 at edge N: BLANK entered at edge N+1; first `dig_en` high at edge N+1+BLANK_CYCLES.
- IDLE load latency: `load` at edge N → `load_ack` and new `active` at edge N+1.
- Running load latency: `load_ack` appears at the next frame boundary, the same edge as `frame_tick`.

## Test plan
Parameters for all tests: NUM_DIGITS=4, SHOW_CYCLES=4, BLANK_CYCLES=1.
- Reset/idle:
  - Stimulus: `rst` 2 cycles, `enable`=0.
  - Required: all outputs 0; `load` of 0x1234 → `load_ack` 1 cycle later; `dig_en` stays 0.
- Basic scan:
  - Stimulus: `active`=0x1234, `enable`=1.
  - Required: `dig_en` sequence 0000, 0001×4, 0000, 0010×4, 0000, 0100×4, 0000, 1000×4; BCD 4,3,2,1 on successive slots; `frame_tick` every 20 cycles.
- Double-buffer:
  - Stimulus: `load` 0x5678 mid-frame, then `load` 0x9999 before the boundary.
  - Required: the current frame still shows 0x1234; at the boundary, a single `load_ack` and `active`=0x9999.
- Leading-zero blanking:
  - Stimulus: `active`=0x0070, `blank_lz`=1.
  - Required: only digits 0 and 1 lit; with `active`=0x0000, only digit 0 lit, showing 0.
- Invalid code:
  - Stimulus: `active`=0x1A34.
  - Required: digit 2 never lit; `bcd_err`=1 and it stays set after the value is corrected.
- Abort:
  - Stimulus: `enable`=0 during digit 2 SHOW, re-enable 3 cycles later.
  - Required: `dig_en`=0 next cycle; no `frame_tick`; the scan restarts at digit 0.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered BCD word,
// one-hot digit scan with blank gaps, leading-zero and bad-code blanking.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    blank_lz,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  output logic                    b0,
  output logic                    b1,
  output logic                    b2,
  output logic                    b3,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    load_ack,
  output logic                    frame_tick,
  output logic                    bcd_err
);

  localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] SH_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] pending, active, act_nx;
  logic                    pend_v;
  logic [IW-1:0]           idx, nidx;
  logic [CW-1:0]           cnt;
  logic [3:0]              bcd, cur, bcd_nx;
  logic [NUM_DIGITS-1:0]   lz_mask, onehot;
  logic                    last_blank, last_show, frame_end, xfer, supp;

  assign {b3, b2, b1, b0} = bcd;

  always_comb begin
    logic z;
    state_d    = state_q;
    z          = 1'b1;
    lz_mask    = '0;
    last_blank = (state_q == BLANK) && (cnt == BL_LAST);
    last_show  = (state_q == SHOW) && (cnt == SH_LAST);
    frame_end  = enable && last_show && (idx == IX_LAST);
    xfer       = pend_v && (frame_end || state_q == IDLE);
    act_nx     = xfer ? pending : active;
    nidx       = (state_q == IDLE || idx == IX_LAST) ? '0 : idx + 1'b1;
    bcd_nx     = act_nx[{nidx, 2'b00} +: 4];
    cur        = active[{idx, 2'b00} +: 4];
    onehot     = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
    // digit i blanks when it and everything left of it is zero
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z          = z && (active[4*i +: 4] == 4'd0);
      lz_mask[i] = z;
    end
    lz_mask[0] = 1'b0;
    supp       = (cur > 4'd9) || (blank_lz && lz_mask[idx]);
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = BLANK;
        BLANK:   if (last_blank) state_d = SHOW;
        SHOW:    if (last_show) state_d = BLANK;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending    <= '0;
      active     <= '0;
      pend_v     <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      bcd        <= '0;
      dig_en     <= '0;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_ack   <= xfer;
      frame_tick <= frame_end;
      if (xfer) begin
        active <= pending;
        pend_v <= 1'b0;
      end
      if (load) begin
        pending <= value_in;
        pend_v  <= 1'b1;
      end
      if (!enable) begin
        idx    <= '0;
        cnt    <= '0;
        dig_en <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            idx    <= '0;
            cnt    <= '0;
            dig_en <= '0;
            bcd    <= bcd_nx;
          end
          BLANK: begin
            if (last_blank) begin
              cnt    <= '0;
              dig_en <= supp ? '0 : onehot;
              if (cur > 4'd9) bcd_err <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SHOW: begin
            if (last_show) begin
              cnt    <= '0;
              idx    <= nidx;
              dig_en <= '0;
              bcd    <= bcd_nx;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            idx    <= '0;
            cnt    <= '0;
            dig_en <= '0;
          end
        endcase
      end
    end
  end

endmodule
